fifo_umbrales: RTL and testbench

Synchronous single-clock FIFO with programmable almost-full and almost-empty thresholds. It is used as both the input-side and output-side FIFO around the 4-channel arbiter.
- Its `empty` output feeds the arbiter's emptyN inputs.
- Its `almost_full` output feeds the arbiter's afullN inputs.
- Its `push`/`pop` inputs are driven by the arbiter's pushN_out/popN_out.

It provides a registered read port, occupancy count and a sticky overflow/underflow error flag.

---
 rtl/fifo_umbrales.sv | 91 +++++++++
 tb/tb_fifo_umbrales.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_umbrales.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// registered read port, occupancy count and a sticky overflow/underflow flag.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_out_reg;
    logic                  fifo_error_reg;

    logic wr_acc;
    logic pop_acc;
    logic error_next;

    // Flags come straight from the registered count so the arbiter sees them this cycle.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH);
    assign almost_full  = (count_reg >= umbral_af);
    assign almost_empty = (count_reg <= umbral_ae);

    assign pop_acc    = pop && reset && !empty;
    assign wr_acc     = push && reset && (!full || pop_acc);
    assign error_next = (push && full && !pop) || (pop && empty);

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_out_reg   <= '0;
            valid_out_reg  <= 1'b0;
            fifo_error_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_acc) begin
                data_out_reg  <= mem[rd_ptr_reg];
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                valid_out_reg <= 1'b1;
            end else begin
                valid_out_reg <= 1'b0;
            end
            case ({wr_acc, pop_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (error_next) begin
                fifo_error_reg <= 1'b1;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign valid_out  = valid_out_reg;
    assign fifo_error = fifo_error_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Randomized self-checking bench for fifo_umbrales against a queue-based
// reference model; one line per transaction.
module tb_fifo_umbrales;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] data_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] umbral_af = 4'd6;
    logic [3:0] umbral_ae = 4'd2;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_error;
    logic [3:0] count;

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .count        (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the FIFO is just a queue of words plus a few scalars.
    logic [5:0] model_q[$];
    logic [5:0] model_dout = '0;
    logic       model_vout = 1'b0;
    logic       model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic p, input logic o, input logic [5:0] d);
        int n;
        logic pop_ok;
        n = model_q.size();
        if (!r) begin
            model_q.delete();
            model_dout = '0;
            model_vout = 1'b0;
            model_err  = 1'b0;
        end else begin
            pop_ok = o && (n > 0);
            if ((p && n == 8 && !o) || (o && n == 0)) model_err = 1'b1;
            if (pop_ok) begin
                model_dout = model_q.pop_front();
                model_vout = 1'b1;
            end else begin
                model_vout = 1'b0;
            end
            if (p && (n < 8 || pop_ok)) model_q.push_back(d);
        end
    endtask

    task automatic check_outputs(input string ph);
        int n;
        n = model_q.size();
        check({ph, ".count"},        32'(count),        32'(n));
        check({ph, ".empty"},        32'(empty),        32'(n == 0));
        check({ph, ".full"},         32'(full),         32'(n == 8));
        check({ph, ".almost_full"},  32'(almost_full),  32'(n >= int'(umbral_af)));
        check({ph, ".almost_empty"}, 32'(almost_empty), 32'(n <= int'(umbral_ae)));
        check({ph, ".fifo_error"},   32'(fifo_error),   32'(model_err));
        check({ph, ".valid_out"},    32'(valid_out),    32'(model_vout));
        check({ph, ".data_out"},     32'(data_out),     32'(model_dout));
    endtask

    // Drive one cycle, clock it, then compare every output against the model.
    task automatic step(input string ph, input logic r, input logic p, input logic o, input logic [5:0] d);
        reset = r; push = p; pop = o; data_in = d;
        @(posedge clk);
        model_edge(r, p, o, d);
        #1;
        check_outputs(ph);
        $display("%s: rst_n=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h valid=%0b err=%0b",
                 ph, r, p, o, d, count, data_out, valid_out, fifo_error);
    endtask

    initial begin
        // Reset held with push asserted must not store anything.
        step("reset", 1'b0, 1'b1, 1'b0, 6'h15);
        step("reset", 1'b0, 1'b1, 1'b0, 6'h15);
        // Pop right after release: stale memory must not show up as valid.
        step("post_reset_pop", 1'b1, 1'b0, 1'b1, 6'h00);
        step("reset2", 1'b0, 1'b0, 1'b0, 6'h00);

        umbral_af = 4'd6;
        umbral_ae = 4'd2;
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b1, 1'b0, 6'(i));
        for (int i = 0; i < 8; i++)  step("drain", 1'b1, 1'b0, 1'b1, 6'h00);

        for (int i = 1; i <= 8; i++) step("refill", 1'b1, 1'b1, 1'b0, 6'(i));
        step("overflow", 1'b1, 1'b1, 1'b0, 6'h3F);
        step("full_pushpop", 1'b1, 1'b1, 1'b1, 6'h2A);
        for (int i = 0; i < 8; i++)  step("drain2", 1'b1, 1'b0, 1'b1, 6'h00);

        step("empty_pushpop", 1'b1, 1'b1, 1'b1, 6'h11);
        step("pop_11", 1'b1, 1'b0, 1'b1, 6'h00);

        for (int i = 0; i < 3; i++)  step("prime", 1'b1, 1'b1, 1'b0, 6'($urandom));
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, 1'b1, 6'($urandom));
        step("mid_reset", 1'b0, 1'b1, 1'b1, 6'h2B);

        // Random traffic with moving thresholds and occasional reset.
        for (int i = 0; i < 300; i++) begin
            umbral_af = 4'($urandom_range(0, 8));
            umbral_ae = 4'($urandom_range(0, 8));
            step("random", ($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0), 6'($urandom));
        end

        // Thresholds alone must move the flags with no clock edge.
        for (int t = 0; t <= 8; t++) begin
            umbral_af = 4'(t);
            umbral_ae = 4'(8 - t);
            #1;
            check("thr.almost_full",  32'(almost_full),  32'(model_q.size() >= t));
            check("thr.almost_empty", 32'(almost_empty), 32'(model_q.size() <= 8 - t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
